axil_adder_bank: RTL
====================

Name: axil_adder_bank

Overview:
- Parametrised AXI4-Lite slave that sums up to NUM_OPERANDS software-loaded operands sequentially, one operand per clock.
- Returns a full-precision result (low word plus carry word), with overflow flag, busy/done status and optional interrupt.
- Sits on the s1 AXI4-Lite peripheral bus as a next-generation replacement for the fixed two-operand adder.
- Fully AXI4-Lite-compliant: valid/ready handshakes, held responses, SLVERR on illegal accesses.

Parameters:
DATA_WIDTH, 32, AXI data width and operand width (multiple of 8, 32 or 64).
ADDR_WIDTH, 8, AXI address width (byte address).
NUM_OPERANDS, 4, operand register count, 2..56.
CARRY_WIDTH, $clog2(NUM_OPERANDS), width of carry word; derived, not overridden.

Ports:
s1_axi_aclk  input  1  single clock, all logic on rising edge.
s1_axi_areset  input  1  synchronous, active-high reset.
s1_axi_awaddr  input  ADDR_WIDTH  write address.
s1_axi_awvalid  input  1  write address valid.
s1_axi_awready  output  1  write address ready.
s1_axi_wdata  input  DATA_WIDTH  write data.
s1_axi_wstrb  input  DATA_WIDTH/8  byte strobes.
s1_axi_wvalid  input  1  write data valid.
s1_axi_wready  output  1  write data ready.
s1_axi_bresp  output  2  write response (0=OKAY, 2=SLVERR).
s1_axi_bvalid  output  1  write response valid.
s1_axi_bready  input  1  write response ready.
s1_axi_araddr  input  ADDR_WIDTH  read address.
s1_axi_arvalid  input  1  read address valid.
s1_axi_arready  output  1  read address ready.
s1_axi_rdata  output  DATA_WIDTH  read data.
s1_axi_rresp  output  2  read response.
s1_axi_rvalid  output  1  read data valid.
s1_axi_rready  input  1  read data ready.

Behaviour:

Reset:
- All outputs 0 (rdata 0, never Z).
- Operands, COUNT=NUM_OPERANDS, result, status and IRQ_EN all cleared.
- Reset mid-sum aborts the sum; DONE stays 0.

Register map (word-aligned; addr[1:0] ignored):
- 0x00 CTRL: b0 START (W, self-clearing, reads 0); b1 CLR (W, zeroes RESULT/OVF/DONE, reads 0); b2 IRQ_EN (RW).
- 0x04 STATUS: b0 BUSY (RO); b1 DONE (sticky, W1C); b2 OVF (RO).
- 0x08 COUNT: RW, legal range 1..NUM_OPERANDS.
- 0x0C RESULT_LO: RO.
- 0x10 RESULT_HI: RO, carry zero-extended.
- 0x20+4*i: OPERAND[i], RW, byte-masked by wstrb.
- Any other address: SLVERR; write dropped, read returns 0.

Write channel:
- awready and wready pulse together for one cycle when awvalid & wvalid & !bvalid.
- Register update happens in the handshake cycle (visible next cycle).
- bvalid rises the cycle after the handshake and is held, with bresp stable, until bready.
- No new write is accepted while bvalid=1.

Read channel:
- arready pulses for one cycle when arvalid & !rvalid.
- rvalid/rdata/rresp appear the next cycle and are held until rready.
- rdata is the register value at the handshake cycle.

SLVERR writes (no state change):
- COUNT written with 0 or >NUM_OPERANDS.
- START or CLR written while BUSY.
- OPERAND or COUNT written while BUSY.

Sum FSM (IDLE -> SUM -> IDLE):
- Legal START accepted at cycle T: acc cleared, idx=0, DONE cleared, BUSY=1 from T+1.
- Cycles T+1..T+COUNT: acc += OPERAND[idx], idx++.
- Accumulator width is DATA_WIDTH+CARRY_WIDTH, unsigned.
- At T+COUNT+1: RESULT <= acc, OVF = (carry != 0), DONE=1, BUSY=0, FSM returns to IDLE.
- RESULT registers hold the last completed sum during SUM.
- Write of START=1 and CLR=1 in the same beat: CLR applied first, then START.
- DONE W1C in the same cycle DONE sets: set wins.

Optional Feature:
- Macro ADDER_IRQ_EN.
- Defined: adds output port irq (1 bit, reset 0) = DONE & IRQ_EN, registered; cleared via W1C of DONE or CLR.
- Undefined: no irq port; CTRL.b2 is not writable and reads 0.

Test Plan:
- Reset, then read 0x08 -> 4; read 0x04 -> 0; read 0x0C -> 0; all bresp/rresp OKAY.
- Load OPERAND0..3 = 1,2,3,4; COUNT=4; START -> BUSY for 4 cycles; then RESULT_LO=10, RESULT_HI=0, DONE=1, OVF=0.
- Load four operands of 0xFFFFFFFF, COUNT=4, START -> RESULT_LO=0xFFFFFFFC, RESULT_HI=3, OVF=1.
- Write COUNT=0, write OPERAND1 during BUSY, read 0xF0 -> each returns SLVERR; register contents unchanged.
- Hold bready=0 for 5 cycles after a write, then hold rready=0 for 5 cycles after a read -> bvalid/bresp and rvalid/rdata stay stable; no further handshakes accepted until ready.
- With ADDER_IRQ_EN defined: set IRQ_EN, run sum -> irq=1 one cycle after DONE sets; W1C DONE -> irq=0; assert reset mid-sum -> BUSY=0, irq=0, RESULT=0.

Source files
------------

// File: rtl/axil_adder_bank_if.sv
// AXI4-Lite bus bundle for the s1 peripheral port of axil_adder_bank.
// Signal names match the original flat port list of the block.
//   slave  modport : used by axil_adder_bank
//   master modport : used by the bus master driving the block
interface axil_adder_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr;
  logic                    s1_axi_awvalid;
  logic                    s1_axi_awready;
  logic [DATA_WIDTH-1:0]   s1_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb;
  logic                    s1_axi_wvalid;
  logic                    s1_axi_wready;
  logic [1:0]              s1_axi_bresp;
  logic                    s1_axi_bvalid;
  logic                    s1_axi_bready;
  logic [ADDR_WIDTH-1:0]   s1_axi_araddr;
  logic                    s1_axi_arvalid;
  logic                    s1_axi_arready;
  logic [DATA_WIDTH-1:0]   s1_axi_rdata;
  logic [1:0]              s1_axi_rresp;
  logic                    s1_axi_rvalid;
  logic                    s1_axi_rready;

  modport slave (
    input  s1_axi_awaddr, s1_axi_awvalid, s1_axi_wdata, s1_axi_wstrb, s1_axi_wvalid,
    input  s1_axi_bready, s1_axi_araddr, s1_axi_arvalid, s1_axi_rready,
    output s1_axi_awready, s1_axi_wready, s1_axi_bresp, s1_axi_bvalid,
    output s1_axi_arready, s1_axi_rdata, s1_axi_rresp, s1_axi_rvalid
  );

  modport master (
    output s1_axi_awaddr, s1_axi_awvalid, s1_axi_wdata, s1_axi_wstrb, s1_axi_wvalid,
    output s1_axi_bready, s1_axi_araddr, s1_axi_arvalid, s1_axi_rready,
    input  s1_axi_awready, s1_axi_wready, s1_axi_bresp, s1_axi_bvalid,
    input  s1_axi_arready, s1_axi_rdata, s1_axi_rresp, s1_axi_rvalid
  );
endinterface

// File: rtl/axil_adder_bank.sv
// AXI4-Lite slave summing up to NUM_OPERANDS software-loaded operands,
// one operand per clock, into a full-precision result (low word + carry).
//
// Ports:
//   s1_axi_aclk    : clock, all logic on rising edge
//   s1_axi_areset  : synchronous active-high reset
//   s1             : AXI4-Lite slave bus (axil_adder_bank_if.slave)
//   irq            : registered DONE & IRQ_EN (only when ADDER_IRQ_EN is defined)
//
// Optional feature macro: ADDER_IRQ_EN (adds irq port and writable CTRL.IRQ_EN).
//
// Register map (word aligned, addr[1:0] ignored):
//   0x00 CTRL      b0 START (W), b1 CLR (W), b2 IRQ_EN (RW)
//   0x04 STATUS    b0 BUSY, b1 DONE (W1C), b2 OVF
//   0x08 COUNT     1..NUM_OPERANDS
//   0x0C RESULT_LO
//   0x10 RESULT_HI carry word, zero-extended
//   0x20+4*i       OPERAND[i], byte-masked by wstrb
module axil_adder_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_OPERANDS = 4
) (
  input logic               s1_axi_aclk,
  input logic               s1_axi_areset,
  axil_adder_bank_if.slave  s1
`ifdef ADDER_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CARRY_WIDTH = $clog2(NUM_OPERANDS);
  localparam int ACC_W       = DATA_WIDTH + CARRY_WIDTH;
  localparam int CNT_W       = $clog2(NUM_OPERANDS + 1);
  localparam int OP_IW       = $clog2(NUM_OPERANDS);
  localparam int STRB_W      = DATA_WIDTH / 8;
  localparam int WA_W        = ADDR_WIDTH - 2;

  localparam logic [WA_W-1:0] W_CTRL   = WA_W'(0);
  localparam logic [WA_W-1:0] W_STATUS = WA_W'(1);
  localparam logic [WA_W-1:0] W_COUNT  = WA_W'(2);
  localparam logic [WA_W-1:0] W_RLO    = WA_W'(3);
  localparam logic [WA_W-1:0] W_RHI    = WA_W'(4);
  localparam logic [WA_W-1:0] W_OP0    = WA_W'(8);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef ADDER_IRQ_EN
  localparam logic IRQ_FEATURE = 1'b1;
`else
  localparam logic IRQ_FEATURE = 1'b0;
`endif

  typedef enum logic {IDLE, SUM} state_t;

  // Architectural state
  state_t                  state_q;
  logic [ACC_W-1:0]        acc_q;
  logic [OP_IW-1:0]        idx_q;
  logic [ACC_W-1:0]        result_q;
  logic                    ovf_q;
  logic                    done_q;
  logic [CNT_W-1:0]        count_q;
  logic                    irq_en_q;
  logic [DATA_WIDTH-1:0]   operand_q [NUM_OPERANDS];

  // Bus channel state
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic                    rvalid_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    busy;
  logic                    wr_hs;
  logic                    rd_hs;
  logic [WA_W-1:0]         wr_word;
  logic [WA_W-1:0]         rd_word;
  logic [WA_W-1:0]         wr_off;
  logic [WA_W-1:0]         rd_off;
  logic [OP_IW-1:0]        wr_op_idx;
  logic [OP_IW-1:0]        rd_op_idx;
  logic [DATA_WIDTH-1:0]   wmask;
  logic [DATA_WIDTH-1:0]   cnt_new;
  logic                    wr_err;
  logic                    do_start;
  logic                    do_clr;
  logic                    do_irqen;
  logic                    do_w1c;
  logic                    do_count;
  logic                    do_op;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_err;
  logic [ACC_W-1:0]        acc_sum;
  logic                    last;
  logic                    unused_addr_bits;

  function automatic logic is_op(input logic [WA_W-1:0] w);
    return (w >= W_OP0) && ((w - W_OP0) < WA_W'(NUM_OPERANDS));
  endfunction

  assign busy      = (state_q == SUM);
  assign wr_hs     = !s1_axi_areset && s1.s1_axi_awvalid && s1.s1_axi_wvalid && !bvalid_q;
  assign rd_hs     = !s1_axi_areset && s1.s1_axi_arvalid && !rvalid_q;
  assign wr_word   = s1.s1_axi_awaddr[ADDR_WIDTH-1:2];
  assign rd_word   = s1.s1_axi_araddr[ADDR_WIDTH-1:2];
  assign wr_off    = wr_word - W_OP0;
  assign rd_off    = rd_word - W_OP0;
  assign wr_op_idx = wr_off[OP_IW-1:0];
  assign rd_op_idx = rd_off[OP_IW-1:0];

  assign unused_addr_bits = ^{s1.s1_axi_awaddr[1:0], s1.s1_axi_araddr[1:0], wr_off, rd_off};

  assign s1.s1_axi_awready = wr_hs;
  assign s1.s1_axi_wready  = wr_hs;
  assign s1.s1_axi_arready = rd_hs;
  assign s1.s1_axi_bvalid  = bvalid_q;
  assign s1.s1_axi_bresp   = bresp_q;
  assign s1.s1_axi_rvalid  = rvalid_q;
  assign s1.s1_axi_rresp   = rresp_q;
  assign s1.s1_axi_rdata   = rdata_q;

  assign acc_sum = acc_q + ACC_W'(operand_q[idx_q]);
  assign last    = (CNT_W'(idx_q) == count_q - CNT_W'(1));

  // Write decode: every action flag is qualified by the handshake and
  // suppressed when the access is answered with SLVERR.
  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      wmask[8*b +: 8] = {8{s1.s1_axi_wstrb[b]}};
    end
    cnt_new  = (DATA_WIDTH'(count_q) & ~wmask) | (s1.s1_axi_wdata & wmask);
    wr_err   = 1'b0;
    do_start = 1'b0;
    do_clr   = 1'b0;
    do_irqen = 1'b0;
    do_w1c   = 1'b0;
    do_count = 1'b0;
    do_op    = 1'b0;
    if (wr_hs) begin
      case (wr_word)
        W_CTRL: begin
          if (s1.s1_axi_wstrb[0]) begin
            if (busy && (s1.s1_axi_wdata[0] || s1.s1_axi_wdata[1])) begin
              wr_err = 1'b1;
            end else begin
              do_start = s1.s1_axi_wdata[0];
              do_clr   = s1.s1_axi_wdata[1];
              do_irqen = 1'b1;
            end
          end
        end
        W_STATUS: do_w1c = s1.s1_axi_wstrb[0] && s1.s1_axi_wdata[1];
        W_COUNT: begin
          if (busy || (cnt_new == '0) || (cnt_new > DATA_WIDTH'(NUM_OPERANDS))) begin
            wr_err = 1'b1;
          end else begin
            do_count = 1'b1;
          end
        end
        W_RLO, W_RHI: ;
        default: begin
          if (is_op(wr_word) && !busy) begin
            do_op = 1'b1;
          end else begin
            wr_err = 1'b1;
          end
        end
      endcase
    end
  end

  // Read mux: value sampled in the address handshake cycle.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_word)
      W_CTRL:   rd_data[2]   = irq_en_q;
      W_STATUS: rd_data[2:0] = {ovf_q, done_q, busy};
      W_COUNT:  rd_data[CNT_W-1:0] = count_q;
      W_RLO:    rd_data = result_q[DATA_WIDTH-1:0];
      W_RHI:    rd_data[CARRY_WIDTH-1:0] = result_q[ACC_W-1:DATA_WIDTH];
      default: begin
        if (is_op(rd_word)) begin
          rd_data = operand_q[rd_op_idx];
        end else begin
          rd_err = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s1.s1_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        rdata_q  <= rd_data;
      end else if (rvalid_q && s1.s1_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
        operand_q[i] <= '0;
      end
    end else if (do_op) begin
      operand_q[wr_op_idx] <= (operand_q[wr_op_idx] & ~wmask) | (s1.s1_axi_wdata & wmask);
    end
  end

  // Control registers and sum FSM. Statement order encodes priority:
  // CLR before START, and a completing sum sets DONE over a same-cycle W1C.
  // The final operand is folded into RESULT directly so BUSY lasts exactly
  // COUNT cycles.
  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= CNT_W'(NUM_OPERANDS);
      irq_en_q <= 1'b0;
    end else begin
      if (do_irqen) irq_en_q <= s1.s1_axi_wdata[2] & IRQ_FEATURE;
      if (do_count) count_q  <= cnt_new[CNT_W-1:0];
      if (do_w1c)   done_q   <= 1'b0;
      if (do_clr) begin
        result_q <= '0;
        ovf_q    <= 1'b0;
        done_q   <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (do_start) begin
            state_q <= SUM;
            acc_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        SUM: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + OP_IW'(1);
          if (last) begin
            result_q <= acc_sum;
            ovf_q    <= |acc_sum[ACC_W-1:DATA_WIDTH];
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ADDER_IRQ_EN
  logic irq_q;

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= done_q && irq_en_q && !(do_w1c || do_clr);
    end
  end

  assign irq = irq_q;
`endif

endmodule
